// File: rtl/mem_ctrl.sv
// Memory / memory-mapped I/O access controller: turns level-held Mem_OE/Mem_WE into a timed async-SRAM cycle or an I/O access.
// Latency: SRAM read READ_WAIT+1 cycles, SRAM write WRITE_WIDTH+3 cycles, I/O access 1 cycle, all to Mem_Ready.
// Backpressure: requests are taken only in IDLE; Mem_Ready is held until both strobes drop, then one idle cycle follows.
module mem_ctrl #(
  parameter int          READ_WAIT   = 2,
  parameter int          WRITE_WIDTH = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_In,
  input  logic [15:0] Switches,
  input  logic [15:0] SRAM_DQ_In,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic [15:0] HEX_Reg,
  output logic [19:0] ADDR,
  output logic [15:0] SRAM_DQ_Out,
  output logic        Data_drive,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic        UB_N,
  output logic        LB_N
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Counter reload values: the state is left on the edge where the count is already zero.
  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_WIDTH - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       is_io;
  logic       accept;
  logic       ce_n_nxt, oe_n_nxt, we_n_nxt, bytes_n_nxt, drive_nxt;

  assign is_io  = (MAR == IO_ADDR);
  assign accept = (state == IDLE) && (Mem_OE || Mem_WE);

  // Next-state and wait-counter logic; a write request wins over a simultaneous read.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (Mem_WE) begin
          state_nxt = is_io ? DONE : WR_SETUP;
        end else if (Mem_OE) begin
          if (is_io) begin
            state_nxt = DONE;
          end else begin
            state_nxt    = RD;
            wait_cnt_nxt = RD_LOAD;
          end
        end
      end
      RD: begin
        if (wait_cnt == 4'd0) state_nxt = DONE;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      WR_SETUP: begin
        state_nxt    = WR_PULSE;
        wait_cnt_nxt = WR_LOAD;
      end
      WR_PULSE: begin
        if (wait_cnt == 4'd0) state_nxt = WR_HOLD;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      WR_HOLD: state_nxt = DONE;
      DONE: begin
        if (!Mem_OE && !Mem_WE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobe values for the state being entered, so the pins come straight from flops.
  always_comb begin
    ce_n_nxt    = 1'b1;
    oe_n_nxt    = 1'b1;
    we_n_nxt    = 1'b1;
    bytes_n_nxt = 1'b1;
    drive_nxt   = 1'b0;
    case (state_nxt)
      RD: begin
        ce_n_nxt    = 1'b0;
        oe_n_nxt    = 1'b0;
        bytes_n_nxt = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_nxt    = 1'b0;
        bytes_n_nxt = 1'b0;
        drive_nxt   = 1'b1;
      end
      WR_PULSE: begin
        ce_n_nxt    = 1'b0;
        we_n_nxt    = 1'b0;
        bytes_n_nxt = 1'b0;
        drive_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // State register, wait counter and registered SRAM/handshake outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      CE_N       <= 1'b1;
      OE_N       <= 1'b1;
      WE_N       <= 1'b1;
      UB_N       <= 1'b1;
      LB_N       <= 1'b1;
      Data_drive <= 1'b0;
      Mem_Ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      CE_N       <= ce_n_nxt;
      OE_N       <= oe_n_nxt;
      WE_N       <= we_n_nxt;
      UB_N       <= bytes_n_nxt;
      LB_N       <= bytes_n_nxt;
      Data_drive <= drive_nxt;
      Mem_Ready  <= (state_nxt == DONE);
    end
  end

  // Address/data capture at acceptance and read-data return; I/O accesses leave the SRAM pins alone.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ADDR        <= 20'd0;
      SRAM_DQ_Out <= 16'd0;
      HEX_Reg     <= 16'd0;
      Data_to_CPU <= 16'd0;
    end else begin
      if (accept && !is_io) begin
        ADDR <= {4'b0000, MAR};
        if (Mem_WE) SRAM_DQ_Out <= MDR_In;
      end
      if (accept && is_io && Mem_WE)            HEX_Reg     <= MDR_In;
      if (accept && is_io && !Mem_WE)           Data_to_CPU <= Switches;
      if (state == RD && wait_cnt == 4'd0)      Data_to_CPU <= SRAM_DQ_In;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a small async-SRAM model.
// Table-driven accesses with a scoreboard queue, plus hand sequences for MAR change, strobe drop and mid-write reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_OE, Mem_WE;
  logic [15:0] MAR, MDR_In, Switches, SRAM_DQ_In;
  logic [15:0] Data_to_CPU, HEX_Reg, SRAM_DQ_Out;
  logic        Mem_Ready, Data_drive, CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [19:0] ADDR;

  int checks = 0;
  int errors = 0;

  mem_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR_In(MDR_In), .Switches(Switches), .SRAM_DQ_In(SRAM_DQ_In),
    .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready), .HEX_Reg(HEX_Reg),
    .ADDR(ADDR), .SRAM_DQ_Out(SRAM_DQ_Out), .Data_drive(Data_drive),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N)
  );

  always #5 Clk = ~Clk;

  // SRAM model: combinational read while selected, write sampled while WE_N is low.
  logic [15:0] sram [0:1023];
  assign SRAM_DQ_In = (!CE_N && !OE_N) ? sram[ADDR[9:0]] : 16'h0000;
  always @(negedge Clk) begin
    if (!CE_N && !WE_N && Data_drive) sram[ADDR[9:0]] <= SRAM_DQ_Out;
  end

  typedef struct {
    logic        oe;
    logic        we;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] sw;
    logic [15:0] exp_data;
    logic [15:0] exp_hex;
    int          exp_lat;
    int          exp_oe;
    int          exp_we;
    int          exp_drv;
    int          exp_ce;
  } vec_t;

  vec_t vecs [8];
  vec_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One complete access: request, wait for Mem_Ready (bounded), hold, release.
  task automatic run_access(input vec_t v, input string tag);
    int   lat, n_oe, n_we, n_drv, n_ce;
    bit   seen;
    vec_t e;
    lat = 0; n_oe = 0; n_we = 0; n_drv = 0; n_ce = 0; seen = 1'b0;
    @(negedge Clk);
    Mem_OE = v.oe; Mem_WE = v.we; MAR = v.mar; MDR_In = v.mdr; Switches = v.sw;
    sb.push_back(v);
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      lat++;
      if (!OE_N)      n_oe++;
      if (!WE_N)      n_we++;
      if (Data_drive) n_drv++;
      if (!CE_N)      n_ce++;
      if (Mem_Ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " ready_seen"}, {31'd0, seen}, 32'd1);
    e = sb.pop_front();
    if (seen) begin
      chk({tag, " latency"},     lat,         e.exp_lat);
      chk({tag, " oe_n_low"},    n_oe,        e.exp_oe);
      chk({tag, " we_n_low"},    n_we,        e.exp_we);
      chk({tag, " drive_cyc"},   n_drv,       e.exp_drv);
      chk({tag, " ce_n_low"},    n_ce,        e.exp_ce);
      chk({tag, " data_to_cpu"}, Data_to_CPU, e.exp_data);
      chk({tag, " hex_reg"},     HEX_Reg,     e.exp_hex);
      if (e.mar != 16'hFFFF) chk({tag, " addr"}, ADDR, {16'd0, e.mar});
    end
    @(posedge Clk);
    @(negedge Clk);
    chk({tag, " ready_held"}, Mem_Ready, 1);
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk({tag, " ready_release"}, Mem_Ready, 0);
  endtask

  initial begin
    vec_t rv;
    for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
    sram[10'h040] = 16'h1234;

    //         oe    we    mar       mdr       sw        data      hex       lat oe we drv ce
    vecs[0] = '{1'b0, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 5, 0, 2, 4, 4};
    vecs[1] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3, 2, 0, 0, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 3, 2, 0, 0, 2};
    vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h00A5, 16'h0000, 1, 0, 0, 0, 0};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 16'h00A5, 16'h5A5A, 1, 0, 0, 0, 0};
    vecs[5] = '{1'b1, 1'b1, 16'h0200, 16'hC0DE, 16'h0000, 16'h00A5, 16'h5A5A, 5, 0, 2, 4, 4};
    vecs[6] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 16'hC0DE, 16'h5A5A, 3, 2, 0, 0, 2};
    vecs[7] = '{1'b1, 1'b1, 16'hFFFF, 16'h1111, 16'h0000, 16'hC0DE, 16'h1111, 1, 0, 0, 0, 0};

    Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0;
    MAR = 16'h0; MDR_In = 16'h0; Switches = 16'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst strobes",     {CE_N, OE_N, WE_N, UB_N, LB_N}, 5'h1F);
    chk("rst drive",       Data_drive,  0);
    chk("rst ready",       Mem_Ready,   0);
    chk("rst data_to_cpu", Data_to_CPU, 0);
    chk("rst hex",         HEX_Reg,     0);
    chk("rst addr",        ADDR,        0);
    chk("rst dq_out",      SRAM_DQ_Out, 0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 8; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // MAR changes while the read is in flight: captured address must hold.
    @(negedge Clk);
    Mem_OE = 1'b1; MAR = 16'h0040;
    @(posedge Clk); @(negedge Clk);
    MAR = 16'h0100;
    @(posedge Clk); @(negedge Clk);
    chk("marchg addr", ADDR, 20'h00040);
    chk("marchg oe_n", OE_N, 0);
    @(posedge Clk); @(negedge Clk);
    chk("marchg ready", Mem_Ready,   1);
    chk("marchg data",  Data_to_CPU, 16'h1234);
    Mem_OE = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("marchg release", Mem_Ready, 0);

    // Strobe dropped during RD: access finishes, DONE lasts one cycle.
    Mem_OE = 1'b1; MAR = 16'h0100;
    @(posedge Clk); @(negedge Clk);
    Mem_OE = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("drop in_rd", OE_N, 0);
    @(posedge Clk); @(negedge Clk);
    chk("drop ready", Mem_Ready,   1);
    chk("drop data",  Data_to_CPU, 16'hBEEF);
    @(posedge Clk); @(negedge Clk);
    chk("drop exit", Mem_Ready, 0);

    // Reset during WR_PULSE.
    Mem_WE = 1'b1; MAR = 16'h0300; MDR_In = 16'h7777;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    chk("wrrst pulse", WE_N, 0);
    Reset = 1'b1;
    @(posedge Clk); @(negedge Clk);
    chk("wrrst we_n",  WE_N,        1);
    chk("wrrst ce_n",  CE_N,        1);
    chk("wrrst drive", Data_drive,  0);
    chk("wrrst ready", Mem_Ready,   0);
    chk("wrrst hex",   HEX_Reg,     0);
    chk("wrrst data",  Data_to_CPU, 0);
    Reset = 1'b0; Mem_WE = 1'b0;

    rv = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3, 2, 0, 0, 2};
    run_access(rv, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory/I-O access controller sitting directly downstream of the control-unit state machine. It converts the level-held Mem_OE / Mem_WE strobes plus the current MAR/MDR into a timed asynchronous-SRAM cycle (or a memory-mapped I/O access), returns read data to the MDR input mux, and reports completion on Mem_Ready. Control-unit states that touch memory can therefore wait on Mem_Ready instead of relying on a hard-coded count of wait states.

## Interface
- READ_WAIT, 2: cycles CE_N/OE_N held low before read data is captured (legal 1..15).
- WRITE_WIDTH, 2: cycles WE_N held low (legal 1..15).
- IO_ADDR, 16'hFFFF: MAR value decoded as I/O instead of SRAM.

- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high.
- Mem_OE  in  1  read request from the control unit, held high until released.
- Mem_WE  in  1  write request from the control unit, held high until released.
- MAR  in  16  access address.
- MDR_In  in  16  write data.
- Switches  in  16  value returned by I/O reads.
- SRAM_DQ_In  in  16  SRAM read data.
- Data_to_CPU  out  16  registered read data, feeding the MDR load mux.
- Mem_Ready  out  1  access complete; level handshake.
- HEX_Reg  out  16  I/O write register, driving the hex displays.
- ADDR  out  20  SRAM address, {4'b0, captured MAR}.
- SRAM_DQ_Out  out  16  SRAM write data.
- Data_drive  out  1  tristate enable for SRAM_DQ_Out.
- CE_N, OE_N, WE_N, UB_N, LB_N  out  1 each  SRAM controls, active-low.

## Operation
- All outputs are registered.
- Reset values:
  - CE_N, OE_N, WE_N, UB_N, LB_N = 1.
  - Data_drive = 0.
  - Mem_Ready = 0.
  - Data_to_CPU, HEX_Reg, ADDR, SRAM_DQ_Out = 0.
  - State = IDLE.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - A request is accepted only in IDLE.
  - On acceptance, MAR and MDR_In are captured. Later changes to them are ignored until the next request.
  - If Mem_OE and Mem_WE are both high, the write wins.
- SRAM read (MAR != IO_ADDR): IDLE → RD.
  - RD lasts READ_WAIT cycles with CE_N = OE_N = UB_N = LB_N = 0.
  - Data_to_CPU <= SRAM_DQ_In on the last RD edge; then → DONE.
- SRAM write: IDLE → WR_SETUP → WR_PULSE → WR_HOLD → DONE.
  - WR_SETUP (1 cycle): CE_N = 0, WE_N = 1, Data_drive = 1.
  - WR_PULSE (WRITE_WIDTH cycles): WE_N = 0.
  - WR_HOLD (1 cycle): WE_N = 1, data still driven.
  - Data_drive drops on entry to DONE.
- I/O read (MAR == IO_ADDR): Data_to_CPU <= Switches; IDLE → DONE. No SRAM pins toggle.
- I/O write: HEX_Reg <= MDR_In; IDLE → DONE. No SRAM pins toggle.
- DONE:
  - Mem_Ready = 1, all SRAM strobes inactive.
  - Stay in DONE while Mem_OE | Mem_WE; go to IDLE the cycle after both are low.
- Data_to_CPU and HEX_Reg hold their values until overwritten.
- A strobe that drops mid-access does not abort the access. The access completes and DONE exits immediately.
- A wait counter (4-bit) is loaded on state entry and decremented each cycle; the state is left when it reaches 0.

## Timing
- Request seen in IDLE on edge N.
- SRAM read: OE_N low cycles N+1..N+READ_WAIT; Mem_Ready high from N+READ_WAIT+1. Default latency 3 cycles.
- SRAM write: WE_N low cycles N+2..N+1+WRITE_WIDTH; Mem_Ready high from N+WRITE_WIDTH+3. Default latency 5 cycles.
- I/O access: Mem_Ready high from N+1.
- Release: strobes low at edge M → Mem_Ready low and IDLE at M+1. A new request is accepted at the earliest at M+1.
- Back-to-back accesses therefore cost at least one idle cycle.
- Reset asserted mid-access: at the next edge all strobes go inactive, Data_drive = 0, Mem_Ready = 0, state = IDLE, and HEX_Reg / Data_to_CPU are cleared.

## Test plan
- SRAM read: SRAM model holds 16'h1234 at 0x0040; Mem_OE=1, MAR=0x0040 → OE_N low exactly 2 cycles, Data_to_CPU=16'h1234, Mem_Ready high 3 cycles after the request and held until Mem_OE drops.
- SRAM write: MAR=0x0100, MDR_In=16'hBEEF, Mem_WE=1 → WE_N low 2 cycles, Data_drive high 4 cycles, then a read of 0x0100 returns 16'hBEEF.
- I/O: Switches=16'h00A5, read of 0xFFFF → Data_to_CPU=16'h00A5 with Mem_Ready one cycle later and CE_N never low. Write of 16'h5A5A to 0xFFFF → HEX_Reg=16'h5A5A.
- Simultaneous Mem_OE=Mem_WE=1 → write cycle performed. MAR changed during RD → ADDR unchanged.
- Reset asserted during WR_PULSE → next cycle WE_N=1, Data_drive=0, Mem_Ready=0, HEX_Reg=0. A following read completes normally.
